// File: rtl/io_pkg.sv
// Shared types and widths for the host <-> decompressor IO sequencer.
package io_pkg;

  localparam int DATA_W        = 16;
  localparam int RES_W         = 4;
  localparam int LEN_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/io_skid_buf.sv
// Two-entry skid buffer; a push and a pop in the same cycle are both accepted even when full.
module io_skid_buf
  import io_pkg::*;
#(
  parameter int WIDTH = RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             push;
  logic             pop;

  assign out_valid = (count_reg != 2'd0);
  // When full, the slot being popped this cycle is the one the push overwrites.
  assign in_ready  = (count_reg != 2'd2) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (clr) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= in_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/io_sequencer.sv
// Sequences one transaction: load words into the decompressor, then drain result nibbles to the host.
// Optional watchdog: define IO_SEQ_TIMEOUT_EN to enable the handshake timeout and sticky err flag.
module io_sequencer
  import io_pkg::*;
#(
  parameter int LEN_W       = LEN_W_DEFAULT,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic [LEN_W-1:0]  res_len,
  input  logic [DATA_W-1:0] host_din,
  input  logic              host_din_valid,
  output logic              host_din_ready,
  output logic              load,
  output logic [DATA_W-1:0] dec_data,
  input  logic [RES_W-1:0]  res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic [RES_W-1:0]  host_dout,
  output logic              host_dout_valid,
  input  logic              host_dout_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] load_len_reg, res_len_reg;
  logic [LEN_W-1:0] load_cnt_reg, in_cnt_reg, out_cnt_reg;
  logic             in_drain, in_room, res_fire, pop_fire;
  logic             last_load, last_pop, timeout;
  logic             buf_in_valid, buf_in_ready, buf_out_valid, buf_out_ready;
  logic [RES_W-1:0] buf_out_data;

  // Compare against len-1 so a length of 2^LEN_W-1 never wraps a counter.
  assign last_load = (load_cnt_reg == load_len_reg - LEN_W'(1));
  assign last_pop  = (out_cnt_reg == res_len_reg - LEN_W'(1));

  assign in_drain        = (state_reg == DRAIN);
  assign in_room         = (in_cnt_reg != res_len_reg);
  assign buf_in_valid    = in_drain && in_room && res_valid;
  assign res_ready       = in_drain && in_room && buf_in_ready;
  assign buf_out_ready   = in_drain && host_dout_ready;
  assign host_dout_valid = in_drain && buf_out_valid;
  assign host_dout       = buf_out_data;
  assign res_fire        = res_valid && res_ready;
  assign pop_fire        = host_dout_valid && host_dout_ready;
  assign busy            = (state_reg != IDLE);

  io_skid_buf #(.WIDTH(RES_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_reg == FINISH),
    .in_data   (res_data),
    .in_valid  (buf_in_valid),
    .in_ready  (buf_in_ready),
    .out_data  (buf_out_data),
    .out_valid (buf_out_valid),
    .out_ready (buf_out_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      load_len_reg <= '0;
      res_len_reg  <= '0;
      load_cnt_reg <= '0;
      in_cnt_reg   <= '0;
      out_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        load_len_reg <= load_len;
        res_len_reg  <= res_len;
        load_cnt_reg <= '0;
        in_cnt_reg   <= '0;
        out_cnt_reg  <= '0;
      end else begin
        if (load)     load_cnt_reg <= load_cnt_reg + LEN_W'(1);
        if (res_fire) in_cnt_reg   <= in_cnt_reg + LEN_W'(1);
        if (pop_fire) out_cnt_reg  <= out_cnt_reg + LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    host_din_ready = 1'b0;
    load           = 1'b0;
    dec_data       = '0;
    done           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (load_len != '0)     state_next = LOAD;
          else if (res_len != '0) state_next = DRAIN;
          else                    state_next = FINISH;
        end
      end
      LOAD: begin
        host_din_ready = 1'b1;
        load           = host_din_valid;
        dec_data       = host_din;
        if (host_din_valid && last_load)
          state_next = (res_len_reg == '0) ? FINISH : DRAIN;
        else if (timeout)
          state_next = FINISH;
      end
      DRAIN: begin
        if ((pop_fire && last_pop) || timeout) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef IO_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            err_reg;
  logic            wd_active, any_fire;

  assign wd_active = (state_reg == LOAD) || (state_reg == DRAIN);
  assign any_fire  = load || res_fire || pop_fire;
  // Fires on the TIMEOUT_CYC-th consecutive cycle with no handshake.
  assign timeout   = wd_active && !any_fire && (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));
  assign err       = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (!wd_active || any_fire) wd_cnt_reg <= '0;
      else                        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      if (state_reg == IDLE && start) err_reg <= 1'b0;
      else if (timeout)               err_reg <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule
